// File: rtl/vc_input_buffer.sv
// rtl/vc_input_buffer.sv - four-VC input buffer with registered dequeue toward an rr_arbiter
// Optional feature: define VC_BUF_CREDIT_EN to add the per-VC credit_out return pulses.
module vc_input_buffer #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [1:0]        in_vc,
    input  logic [DATA_W-1:0] in_data,
    output logic [3:0]        in_ready,
    output logic [3:0]        request,
    input  logic [2:0]        grant,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        out_vc,
    output logic              overflow_err
`ifdef VC_BUF_CREDIT_EN
    ,
    output logic [3:0]        credit_out
`endif
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [DATA_W-1:0] mem_q [4][DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q [4];
    logic [PTR_W-1:0]  wr_ptr_d [4];
    logic [PTR_W-1:0]  rd_ptr_q [4];
    logic [PTR_W-1:0]  rd_ptr_d [4];
    logic [CNT_W-1:0]  count_q  [4];
    logic [CNT_W-1:0]  count_d  [4];

    logic              out_valid_q;
    logic [DATA_W-1:0] out_data_q;
    logic [1:0]        out_vc_q;
    logic              overflow_q;

    logic              push_ok;
    logic              drop;
    logic              pop_en;
    logic [1:0]        pop_vc;

    // Flow-control flags come from registered counts only, so no input can bypass into request.
    always_comb begin
        in_ready = '0;
        request  = '0;
        for (int n = 0; n < 4; n++) begin
            in_ready[n] = (count_q[n] != FULL_CNT);
            request[n]  = (count_q[n] != '0);
        end
    end

    // Grant codes with bit 2 set are idle; fullness is judged before this edge's pop.
    always_comb begin
        pop_vc  = grant[1:0];
        pop_en  = ~grant[2] & request[pop_vc] & out_ready;
        push_ok = in_valid & in_ready[in_vc];
        drop    = in_valid & ~in_ready[in_vc];
    end

    // Per-VC pointer and occupancy next state; simultaneous push and pop leave the count unchanged.
    always_comb begin
        for (int n = 0; n < 4; n++) begin
            wr_ptr_d[n] = wr_ptr_q[n];
            rd_ptr_d[n] = rd_ptr_q[n];
            count_d[n]  = count_q[n];
            if (push_ok && (in_vc == 2'(n)))
                wr_ptr_d[n] = wr_ptr_q[n] + PTR_W'(1);
            if (pop_en && (pop_vc == 2'(n)))
                rd_ptr_d[n] = rd_ptr_q[n] + PTR_W'(1);
            case ({push_ok && (in_vc == 2'(n)), pop_en && (pop_vc == 2'(n))})
                2'b10:   count_d[n] = count_q[n] + CNT_W'(1);
                2'b01:   count_d[n] = count_q[n] - CNT_W'(1);
                default: count_d[n] = count_q[n];
            endcase
        end
    end

    // Flit storage is not reset; validity is tracked entirely by the counts.
    always_ff @(posedge clk) begin
        if (push_ok)
            mem_q[in_vc][wr_ptr_q[in_vc]] <= in_data;
    end

    // Pointer and count registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int n = 0; n < 4; n++) begin
                wr_ptr_q[n] <= '0;
                rd_ptr_q[n] <= '0;
                count_q[n]  <= '0;
            end
        end else begin
            for (int n = 0; n < 4; n++) begin
                wr_ptr_q[n] <= wr_ptr_d[n];
                rd_ptr_q[n] <= rd_ptr_d[n];
                count_q[n]  <= count_d[n];
            end
        end
    end

    // Registered dequeue port; data and VC hold their last values when nothing is popped.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_vc_q    <= '0;
            overflow_q  <= 1'b0;
        end else begin
            out_valid_q <= pop_en;
            if (pop_en) begin
                out_data_q <= mem_q[pop_vc][rd_ptr_q[pop_vc]];
                out_vc_q   <= pop_vc;
            end
            overflow_q <= overflow_q | drop;
        end
    end

    assign out_valid    = out_valid_q;
    assign out_data     = out_data_q;
    assign out_vc       = out_vc_q;
    assign overflow_err = overflow_q;

`ifdef VC_BUF_CREDIT_EN
    logic [3:0] credit_q;

    // One-cycle credit return per popped flit, aligned with out_valid.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            credit_q <= '0;
        else
            credit_q <= pop_en ? (4'b0001 << pop_vc) : 4'b0000;
    end

    assign credit_out = credit_q;
`endif

endmodule

// File: tb/tb_vc_input_buffer.sv
// tb/tb_vc_input_buffer.sv - directed self-checking bench for vc_input_buffer
module tb_vc_input_buffer;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [1:0]  in_vc;
    logic [31:0] in_data;
    logic [3:0]  in_ready;
    logic [3:0]  request;
    logic [2:0]  grant;
    logic        out_ready;
    logic        out_valid;
    logic [31:0] out_data;
    logic [1:0]  out_vc;
    logic        overflow_err;
`ifdef VC_BUF_CREDIT_EN
    logic [3:0]  credit_out;
`endif

    int checks   = 0;
    int failures = 0;

    vc_input_buffer #(.DATA_W(32), .DEPTH(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_vc        (in_vc),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .request      (request),
        .grant        (grant),
        .out_ready    (out_ready),
        .out_valid    (out_valid),
        .out_data     (out_data),
        .out_vc       (out_vc),
        .overflow_err (overflow_err)
`ifdef VC_BUF_CREDIT_EN
        ,
        .credit_out   (credit_out)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [1:0] vc, input logic [31:0] d);
        in_valid = 1'b1;
        in_vc    = vc;
        in_data  = d;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_vc     = 2'd0;
        in_data   = 32'h0;
        grant     = 3'b111;
        out_ready = 1'b0;
        tick();
        tick();
        chk("rst_request", 32'(request), 32'h0);
        chk("rst_in_ready", 32'(in_ready), 32'hF);
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_out_data", out_data, 32'h0);
        chk("rst_out_vc", 32'(out_vc), 32'h0);
        chk("rst_overflow", 32'(overflow_err), 32'h0);
`ifdef VC_BUF_CREDIT_EN
        chk("rst_credit", 32'(credit_out), 32'h0);
`endif
        reset = 1'b0;

        // Four flits into VC1, then drain with grant=1.
        in_valid = 1'b1;
        in_vc    = 2'd1;
        in_data  = 32'hA0;
        #1;
        chk("no_bypass_request", 32'(request), 32'h0);
        tick();
        chk("req_after_write", 32'(request), 32'h2);
        for (int i = 1; i < 4; i++) begin
            in_data = 32'hA0 + 32'(i);
            tick();
        end
        in_valid = 1'b0;
        chk("vc1_full_in_ready", 32'(in_ready), 32'hD);
        grant     = 3'b001;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("vc1_valid", 32'(out_valid), 32'h1);
            chk("vc1_data", out_data, 32'hA0 + 32'(i));
            chk("vc1_vc", 32'(out_vc), 32'h1);
`ifdef VC_BUF_CREDIT_EN
            chk("vc1_credit", 32'(credit_out), 32'h2);
`endif
        end
        chk("vc1_empty_request", 32'(request), 32'h0);
        tick();
        chk("vc1_drained_valid", 32'(out_valid), 32'h0);
        chk("vc1_data_hold", out_data, 32'hA3);
        chk("vc1_vc_hold", 32'(out_vc), 32'h1);
`ifdef VC_BUF_CREDIT_EN
        chk("vc1_credit_idle", 32'(credit_out), 32'h0);
`endif

        // Five writes into VC2 with no grant: fifth dropped.
        grant = 3'b111;
        for (int i = 0; i < 4; i++) push(2'd2, 32'hB0 + 32'(i));
        chk("vc2_full_in_ready", 32'(in_ready), 32'hB);
        chk("vc2_no_overflow_yet", 32'(overflow_err), 32'h0);
        push(2'd2, 32'hB4);
        chk("vc2_overflow", 32'(overflow_err), 32'h1);
        chk("vc2_request", 32'(request), 32'h4);
        grant = 3'b010;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("vc2_valid", 32'(out_valid), 32'h1);
            chk("vc2_data", out_data, 32'hB0 + 32'(i));
            chk("vc2_vc", 32'(out_vc), 32'h2);
        end
        tick();
        chk("vc2_only_four", 32'(out_valid), 32'h0);
        chk("vc2_overflow_sticky", 32'(overflow_err), 32'h1);

        // Push to full VC0 while popping it: push is dropped.
        grant = 3'b111;
        do_reset();
        chk("rst2_overflow", 32'(overflow_err), 32'h0);
        for (int i = 0; i < 4; i++) push(2'd0, 32'hC0 + 32'(i));
        in_valid = 1'b1;
        in_vc    = 2'd0;
        in_data  = 32'h55;
        grant    = 3'b000;
        tick();
        in_valid = 1'b0;
        chk("vc0_pop_data", out_data, 32'hC0);
        chk("vc0_overflow", 32'(overflow_err), 32'h1);
        chk("vc0_count3_in_ready", 32'(in_ready), 32'hF);
        for (int i = 1; i < 4; i++) begin
            tick();
            chk("vc0_drain_data", out_data, 32'hC0 + 32'(i));
            chk("vc0_drain_valid", 32'(out_valid), 32'h1);
        end
        tick();
        chk("vc0_no_55", 32'(out_valid), 32'h0);

        // VC3 holding one flit: push and pop together.
        grant = 3'b111;
        push(2'd3, 32'hD0);
        in_valid = 1'b1;
        in_vc    = 2'd3;
        in_data  = 32'h77;
        grant    = 3'b011;
        tick();
        in_valid = 1'b0;
        grant    = 3'b111;
        chk("vc3_first_pop", out_data, 32'hD0);
        chk("vc3_first_vc", 32'(out_vc), 32'h3);
        tick();
        chk("vc3_count1_request", 32'(request), 32'h8);
        chk("vc3_idle_valid", 32'(out_valid), 32'h0);
        grant = 3'b011;
        tick();
        chk("vc3_second_pop", out_data, 32'h77);
        chk("vc3_second_valid", 32'(out_valid), 32'h1);
        tick();
        chk("vc3_empty", 32'(request), 32'h0);

        // No-pop conditions.
        grant = 3'b111;
        push(2'd1, 32'hE0);
        grant = 3'b000;
        tick();
        chk("empty_vc_grant", 32'(out_valid), 32'h0);
        grant = 3'b111;
        tick();
        chk("idle_grant", 32'(out_valid), 32'h0);
        grant     = 3'b001;
        out_ready = 1'b0;
        tick();
        chk("stalled_out", 32'(out_valid), 32'h0);
        chk("stalled_request", 32'(request), 32'h2);
        grant     = 3'b101;
        out_ready = 1'b1;
        tick();
        chk("idle_code_101", 32'(out_valid), 32'h0);
        grant = 3'b001;
        tick();
        chk("e0_pop", out_data, 32'hE0);

        // Asynchronous reset with two flits in every VC.
        grant = 3'b111;
        for (int v = 0; v < 4; v++) begin
            push(2'(v), 32'hF0 + 32'(v));
            push(2'(v), 32'hF8 + 32'(v));
        end
        chk("all_request", 32'(request), 32'hF);
        grant = 3'b000;
        tick();
        chk("pre_reset_valid", 32'(out_valid), 32'h1);
        #2;
        reset = 1'b1;
        #1;
        chk("async_request", 32'(request), 32'h0);
        chk("async_in_ready", 32'(in_ready), 32'hF);
        chk("async_out_valid", 32'(out_valid), 32'h0);
        chk("async_out_data", out_data, 32'h0);
        tick();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            grant = 3'(i);
            tick();
            chk("no_stale_flit", 32'(out_valid), 32'h0);
`ifdef VC_BUF_CREDIT_EN
            chk("no_stale_credit", 32'(credit_out), 32'h0);
`endif
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vc_input_buffer.md
VC_INPUT_BUFFER -- requirements
Module: vc_input_buffer

Interface
REQ-001 SHALL have parameter DATA_W, default 32: flit width in bits.
REQ-002 SHALL have parameter DEPTH, default 4: flits per VC FIFO; power of two, 2..16.
REQ-003 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port in_valid  input  1  write strobe for an incoming flit.
REQ-006 SHALL have port in_vc  input  2  target VC (0..3) of the incoming flit.
REQ-007 SHALL have port in_data  input  DATA_W  incoming flit.
REQ-008 SHALL have port in_ready  output  4  per-VC "not full" (bit n = VC n accepts a write).
REQ-009 SHALL have port request  output  4  per-VC "not empty"; drives the rr_arbiter request inputs.
REQ-010 SHALL have port grant  input  3  arbiter grant: 0..3 selects a VC; 3'b111 or any other code means idle.
REQ-011 SHALL have port out_ready  input  1  downstream can accept a flit this cycle.
REQ-012 SHALL have port out_valid  output  1  out_data/out_vc hold a valid flit this cycle.
REQ-013 SHALL have port out_data  output  DATA_W  dequeued flit.
REQ-014 SHALL have port out_vc  output  2  VC the dequeued flit came from.
REQ-015 SHALL have port overflow_err  output  1  sticky flag for a dropped write.

Function
REQ-016 SHALL hold four independent circular FIFOs of DEPTH entries, each with write pointer, read pointer (log2(DEPTH) bits, wrapping DEPTH-1 -> 0) and occupancy count (log2(DEPTH)+1 bits).
REQ-017 SHALL derive in_ready[n] = (count[n] != DEPTH) and request[n] = (count[n] != 0) from registered counts only.
REQ-018 SHALL push in_data into FIFO in_vc when in_valid=1 and in_ready[in_vc]=1; count +1, write pointer +1.
REQ-019 SHALL drop a write with in_valid=1 and in_ready[in_vc]=0, leave FIFO state unchanged, and set overflow_err on the next edge.
REQ-020 SHALL pop FIFO g when grant=g (0..3), request[g]=1 and out_ready=1; at most one pop per cycle.
REQ-021 SHALL perform no pop when grant is idle, grant selects an empty VC, or out_ready=0.
REQ-022 SHALL register the popped flit: out_valid=1, out_data=head flit, out_vc=g in the cycle after the pop (latency 1).
REQ-023 SHALL drive out_valid=0 in any cycle not following a pop; out_data and out_vc hold their last values.
REQ-024 SHALL allow push and pop on the same VC in one cycle: count unchanged, both pointers advance.
REQ-025 SHALL not bypass: a flit written into an empty VC raises request one cycle after the write edge and is poppable no earlier.
REQ-026 SHALL judge fullness on the pre-edge count: a push to a full VC is dropped even if the same VC is popped that cycle.
REQ-027 SHALL preserve FIFO order within each VC; no ordering between VCs is implied.

Reset
REQ-028 SHALL, while reset=1, clear all pointers and counts, drive request=4'b0000, in_ready=4'b1111, out_valid=0, out_data=0, out_vc=0, overflow_err=0.
REQ-029 SHALL discard all buffered flits when reset asserts mid-operation, with no flit emitted afterwards.
REQ-030 SHALL clear overflow_err only by reset.

Configuration
REQ-031 SHALL, with VC_BUF_CREDIT_EN defined, add output port credit_out (4 bits), bit n pulsing high for exactly one cycle, in the cycle after each pop from VC n, reset to 0.
REQ-032 SHALL, without VC_BUF_CREDIT_EN, omit credit_out and all related logic; all other behaviour is identical.

Verification (DATA_W=32, DEPTH=4)
REQ-033 SHALL cover: write 0xA0..0xA3 to VC1, grant=3'b001, out_ready=1 -> out_valid 4 consecutive cycles, out_data A0,A1,A2,A3, out_vc=1, then request[1]=0.
REQ-034 SHALL cover: 5 writes to VC2 with no grant -> in_ready[2]=0 after the 4th, 5th write dropped, overflow_err=1, later pops return only 4 flits.
REQ-035 SHALL cover: VC0 full, simultaneous push 0x55 and pop with grant=0 -> write dropped, count=3, overflow_err=1.
REQ-036 SHALL cover: VC3 holding 1 flit, push 0x77 and pop in the same cycle -> count stays 1, next pop returns 0x77.
REQ-037 SHALL cover: grant=0 with VC0 empty, or grant=3'b111 -> no pop, out_valid=0; out_ready=0 with grant=1 and VC1 non-empty -> no pop.
REQ-038 SHALL cover: reset asserted with 2 flits in each VC -> request=0, in_ready=4'b1111, out_valid=0 immediately; no stale flit after release; with VC_BUF_CREDIT_EN, one credit_out pulse per pop.
